// File: rtl/divider_seq.sv
// Multi-cycle radix-2 restoring divider, signed/unsigned, tagged.
// Ports: clk/rst_n, in_* request (valid/ready), out_* result (valid/ready), busy.
module divider_seq #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic             out_dbz,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MINV =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH:0]   acc, acc_n;
  logic [WIDTH-1:0] qr, qr_n;
  logic [WIDTH-1:0] ym, ym_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             neg_q, neg_q_n;
  logic             neg_r, neg_r_n;
  logic             ovf_p, ovf_p_n;
  logic [TAG_W-1:0] tag, tag_n;

  logic [WIDTH-1:0] oq_n, or_n;
  logic             odbz_n, oovf_n;
  logic [TAG_W-1:0] otag_n;

  logic [WIDTH:0]   sh, dif, acc_s;
  logic [WIDTH-1:0] qs;
  logic             ge;
  logic             xneg, yneg;
  logic [WIDTH-1:0] xm, ym_in;

  // one restoring step on the current accumulator/quotient pair
  always_comb begin
    sh    = {acc[WIDTH-1:0], qr[WIDTH-1]};
    dif   = sh - {1'b0, ym};
    ge    = (sh >= {1'b0, ym});
    acc_s = ge ? dif : sh;
    qs    = {qr[WIDTH-2:0], ge};
  end

  // most-negative negates to 2^(WIDTH-1), still correct as unsigned
  always_comb begin
    xneg  = in_signed & in_x[WIDTH-1];
    yneg  = in_signed & in_y[WIDTH-1];
    xm    = xneg ? -in_x : in_x;
    ym_in = yneg ? -in_y : in_y;
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    qr_n    = qr;
    ym_n    = ym;
    cnt_n   = cnt;
    neg_q_n = neg_q;
    neg_r_n = neg_r;
    ovf_p_n = ovf_p;
    tag_n   = tag;
    oq_n    = out_q;
    or_n    = out_r;
    odbz_n  = out_dbz;
    oovf_n  = out_ovf;
    otag_n  = out_tag;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_y == '0) begin
            state_n = DONE;
            oq_n    = '1;
            or_n    = in_x;
            odbz_n  = 1'b1;
            oovf_n  = 1'b0;
            otag_n  = in_tag;
          end else begin
            state_n = RUN;
            acc_n   = '0;
            qr_n    = xm;
            ym_n    = ym_in;
            cnt_n   = '0;
            neg_q_n = xneg ^ yneg;
            neg_r_n = xneg;
            ovf_p_n = in_signed
                    & (in_x == MINV)
                    & (&in_y);
            tag_n   = in_tag;
          end
        end
      end
      RUN: begin
        acc_n = acc_s;
        qr_n  = qs;
        cnt_n = cnt + 1'b1;
        if (cnt == LAST) begin
          state_n = DONE;
          oq_n    = neg_q ? -qs : qs;
          or_n    = neg_r ? -acc_s[WIDTH-1:0]
                          : acc_s[WIDTH-1:0];
          odbz_n  = 1'b0;
          oovf_n  = ovf_p;
          otag_n  = tag;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      qr      <= '0;
      ym      <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      ovf_p   <= 1'b0;
      tag     <= '0;
      out_q   <= '0;
      out_r   <= '0;
      out_dbz <= 1'b0;
      out_ovf <= 1'b0;
      out_tag <= '0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      qr      <= qr_n;
      ym      <= ym_n;
      cnt     <= cnt_n;
      neg_q   <= neg_q_n;
      neg_r   <= neg_r_n;
      ovf_p   <= ovf_p_n;
      tag     <= tag_n;
      out_q   <= oq_n;
      out_r   <= or_n;
      out_dbz <= odbz_n;
      out_ovf <= oovf_n;
      out_tag <= otag_n;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_divider_seq.sv
// Directed bench for divider_seq (WIDTH=8) with an arithmetic model
// and a scoreboard checking every valid result cycle.
module tb_divider_seq;

  localparam int W  = 8;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_signed = 1'b0;
  logic [W-1:0]  in_x = '0;
  logic [W-1:0]  in_y = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_q;
  logic [W-1:0]  out_r;
  logic          out_dbz;
  logic          out_ovf;
  logic [TW-1:0] out_tag;
  logic          busy;

  divider_seq #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .in_x(in_x),
    .in_y(in_y), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_r(out_r),
    .out_dbz(out_dbz), .out_ovf(out_ovf),
    .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic          dbz;
    logic          ovf;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_err = 0;
  int hs = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // truncating division straight from integer arithmetic
  function automatic exp_t model(bit s, logic [W-1:0] x,
                                 logic [W-1:0] y);
    exp_t e;
    int sx, sy, qi, ri;
    e.tag = '0;
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    if (y == 0) begin
      e.q   = '1;
      e.r   = x;
      e.dbz = 1'b1;
    end else begin
      if (s) begin
        sx = $signed(x);
        sy = $signed(y);
        e.ovf = (sx == -128) && (sy == -1);
      end else begin
        sx = int'(x);
        sy = int'(y);
      end
      qi  = sx / sy;
      ri  = sx % sy;
      e.q = qi[W-1:0];
      e.r = ri[W-1:0];
    end
    return e;
  endfunction

  task automatic pin(string nm, bit s, logic [7:0] x, logic [7:0] y,
                     logic [7:0] q, logic [7:0] r, bit dbz, bit ovf);
    exp_t e;
    e = model(s, x, y);
    chk({nm, ".q"}, 32'(e.q), 32'(q));
    chk({nm, ".r"}, 32'(e.r), 32'(r));
    chk({nm, ".dbz"}, 32'(e.dbz), 32'(dbz));
    chk({nm, ".ovf"}, 32'(e.ovf), 32'(ovf));
  endtask

  // present one request, return right after its accept edge
  task automatic accept(bit s, logic [W-1:0] x, logic [W-1:0] y,
                        logic [TW-1:0] t);
    exp_t e;
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_wait", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_signed = s;
    in_x      = x;
    in_y      = y;
    in_tag    = t;
    @(posedge clk);
    e     = model(s, x, y);
    e.tag = t;
    sb.push_back(e);
    #1;
    in_valid  = 1'b0;
    in_signed = ~s;
    in_x      = ~x;
    in_y      = ~y;
    in_tag    = ~t;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // full op: accept, then count edges until out_valid
  task automatic run_op(bit s, logic [W-1:0] x, logic [W-1:0] y,
                        logic [TW-1:0] t);
    int lat;
    accept(s, x, y, t);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", 32'(lat), (y == 0) ? 32'd0 : 32'(W));
  endtask

  initial begin
    int h0;
    fork
      forever begin
        @(negedge clk);
        if (rst_n && out_valid) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_valid: got q=%0h want none",
                     out_q);
          end else begin
            chk("q", 32'(out_q), 32'(sb[0].q));
            chk("r", 32'(out_r), 32'(sb[0].r));
            chk("dbz", 32'(out_dbz), 32'(sb[0].dbz));
            chk("ovf", 32'(out_ovf), 32'(sb[0].ovf));
            chk("tag", 32'(out_tag), 32'(sb[0].tag));
            if (out_ready) begin
              void'(sb.pop_front());
              hs++;
            end
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
      end
    join_none

    pin("m_u100_7", 0, 8'd100, 8'd7, 8'd14, 8'd2, 0, 0);
    pin("m_sn7_2", 1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 0, 0);
    pin("m_s7_n2", 1, 8'h07, 8'hFE, 8'hFD, 8'h01, 0, 0);
    pin("m_sn7_n2", 1, 8'hF9, 8'hFE, 8'h03, 8'hFF, 0, 0);
    pin("m_dbz", 0, 8'h5A, 8'h00, 8'hFF, 8'h5A, 1, 0);
    pin("m_sovf", 1, 8'h80, 8'hFF, 8'h80, 8'h00, 0, 1);
    pin("m_u128", 0, 8'h80, 8'hFF, 8'h00, 8'h80, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_q", 32'(out_q), 32'd0);
    chk("rst_r", 32'(out_r), 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    rst_n = 1'b1;

    run_op(0, 8'd100, 8'd7, 4'd3);
    run_op(1, 8'hF9, 8'h02, 4'd1);
    run_op(1, 8'h07, 8'hFE, 4'd2);
    run_op(1, 8'hF9, 8'hFE, 4'd4);
    run_op(0, 8'h5A, 8'h00, 4'd5);
    run_op(1, 8'h80, 8'hFF, 4'd6);
    run_op(0, 8'h80, 8'hFF, 4'd7);
    run_op(0, 8'hFF, 8'h01, 4'd8);
    run_op(0, 8'h00, 8'h05, 4'd9);
    run_op(1, 8'h7F, 8'h80, 4'd10);
    run_op(0, 8'hC8, 8'h0D, 4'd11);
    run_op(1, 8'h80, 8'h01, 4'd12);
    run_op(1, 8'hF0, 8'h00, 4'd13);
    run_op(0, 8'h01, 8'hFF, 4'd14);
    run_op(1, 8'h80, 8'h80, 4'd15);

    // back-pressure with a competing request held high
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_op(0, 8'd200, 8'd9, 4'd6);
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      in_signed = 1'b0;
      in_x      = 8'd50;
      in_y      = 8'd5;
      in_tag    = 4'd1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    h0 = hs;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_one_hs", 32'(hs), 32'(h0 + 1));
    chk("bp_ready_after", 32'(in_ready), 32'd1);
    chk("bp_valid_after", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("bp_no_extra_hs", 32'(hs), 32'(h0 + 1));
    chk("bp_idle", 32'(busy), 32'd0);

    // reset on the edge of step 3
    accept(1, 8'hF9, 8'h02, 4'd9);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_q", 32'(out_q), 32'd0);
    chk("mr_r", 32'(out_r), 32'd0);
    chk("mr_dbz", 32'(out_dbz), 32'd0);
    chk("mr_ovf", 32'(out_ovf), 32'd0);
    chk("mr_tag", 32'(out_tag), 32'd0);
    run_op(0, 8'd100, 8'd7, 4'd3);
    run_op(1, 8'h07, 8'hFE, 4'd2);

    repeat (3) @(posedge clk);
    #1;
    chk("drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_chk, n_err);
    $finish;
  end

endmodule
